// File: rtl/sync_mem_responder.sv
// sync_mem_responder: 512-byte big-endian memory behind a MOV/MOC handshake.
// An IDLE/BUSY/DONE FSM inserts WAIT_CYCLES+1 BUSY cycles before each access.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses
// with Err; without it, misaligned accesses proceed with modulo-512 wrap.
module sync_mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MOV,
    input  logic        RW,
    input  logic [8:0]  Addr,
    input  logic [31:0] DataIn,
    input  logic [1:0]  Type,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        rw_q;
    logic [8:0]  addr_q;
    logic [1:0]  type_q;
    logic [31:0] data_q;

    logic [7:0]  mem [0:511];

    logic [8:0]  lane_addr [4];
    logic [7:0]  rd_byte   [4];
    logic [7:0]  wr_byte   [4];
    logic [3:0]  wr_lane;
    logic [31:0] rd_data;
    logic        misaligned;
    logic        reject;
    logic        access_now;

    // Byte-lane addressing, read assembly and write-lane selection for the latched request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        misaligned = 1'b0;
        rd_data    = 32'h0;
        wr_lane    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr_q + 9'(i);   // 9-bit sum wraps modulo 512
            rd_byte[i]   = mem[lane_addr[i]];
            wr_byte[i]   = 8'h00;
        end
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = ((type_q == 2'b01) && addr_q[0]) ||
                     ((type_q == 2'b10) && (addr_q[1:0] != 2'b00));
`endif
        reject     = (type_q == 2'b11) || misaligned;
        access_now = (state == BUSY) && MOV && (wait_cnt == 4'd0) && !Clr;

        // Lowest address carries the most-significant byte of the access.
        case (type_q)
            2'b00: begin
                rd_data    = {24'h0, rd_byte[0]};
                wr_lane    = 4'b0001;
                wr_byte[0] = data_q[7:0];
            end
            2'b01: begin
                rd_data    = {16'h0, rd_byte[0], rd_byte[1]};
                wr_lane    = 4'b0011;
                wr_byte[0] = data_q[15:8];
                wr_byte[1] = data_q[7:0];
            end
            2'b10: begin
                rd_data    = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
                wr_lane    = 4'b1111;
                wr_byte[0] = data_q[31:24];
                wr_byte[1] = data_q[23:16];
                wr_byte[2] = data_q[15:8];
                wr_byte[3] = data_q[7:0];
            end
            default: ;
        endcase
    end

    // Array write port: commits only on the completing BUSY edge of an accepted write.
    // NOTE: the storage array has no reset; Clr must leave its contents intact.
    always_ff @(posedge Clk) begin
        if (access_now && !rw_q && !reject) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_lane[i]) begin
                    mem[lane_addr[i]] <= wr_byte[i];
                end
            end
        end
    end

    // Handshake FSM with registered MOC/Err/DataOut; Clr overrides everything.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (Clr) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            MOC      <= 1'b0;
            Err      <= 1'b0;
            DataOut  <= 32'h0;
            rw_q     <= 1'b0;
            addr_q   <= 9'h0;
            type_q   <= 2'b00;
            data_q   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (MOV) begin
                        rw_q     <= RW;
                        addr_q   <= Addr;
                        type_q   <= Type;
                        data_q   <= DataIn;
                        wait_cnt <= WAIT_INIT;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!MOV) begin
                        state <= IDLE;          // initiator withdrew: abort silently
                    end else if (wait_cnt == 4'd0) begin
                        state <= DONE;
                        MOC   <= 1'b1;
                        Err   <= reject;
                        if (rw_q && !reject) begin
                            DataOut <= rd_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!MOV) begin
                        state <= IDLE;
                        MOC   <= 1'b0;
                        Err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_mem_responder.sv
// Scoreboard bench for sync_mem_responder (WAIT_CYCLES = 3). Expectations for
// misaligned accesses follow MEM_ALIGN_CHECK_EN as seen by this compile.
module tb_sync_mem_responder;

    localparam int W = 3;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Clr;
    logic        MOV;
    logic        RW;
    logic [8:0]  Addr;
    logic [31:0] DataIn;
    logic [1:0]  Type;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Err;

    sync_mem_responder #(.WAIT_CYCLES(W)) dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .MOV     (MOV),
        .RW      (RW),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .Type    (Type),
        .DataOut (DataOut),
        .MOC     (MOC),
        .Err     (Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_dout = 32'h0;
    logic        moc_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: on each MOC rising, pop the next expected response and compare.
    always @(negedge Clk) begin
        exp_t e;
        if (MOC === 1'b1 && moc_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_moc: got MOC=1 expected no response");
            end else begin
                e = sb.pop_front();
                check({e.name, "_data"}, DataOut, e.data);
                check({e.name, "_err"}, 32'(Err), 32'(e.err));
            end
        end
        moc_prev = MOC;
    end

    // Full request: push expectation, drive, check latency/hold/release.
    task automatic do_req(input string name, input bit rw, input logic [8:0] a,
                          input logic [1:0] t, input logic [31:0] d,
                          input logic [31:0] rd_exp, input bit exp_err, input int hold);
        exp_t e;
        int   lat;
        bit   got;
        e.data = (rw && !exp_err) ? rd_exp : model_dout;
        e.err  = exp_err;
        e.name = name;
        model_dout = e.data;
        sb.push_back(e);
        @(negedge Clk);
        MOV = 1'b1; RW = rw; Addr = a; Type = t; DataIn = d;
        lat = 0;
        got = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk);
            #1;
            if (n == 1) begin
                // latched request must ignore later input changes
                RW = ~rw; Addr = ~a; Type = t ^ 2'b01; DataIn = ~d;
            end
            if (MOC === 1'b1) begin
                lat = n;
                got = 1'b1;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(W + 2));
        if (got) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge Clk);
                #1;
                check({name, "_hold_moc"}, 32'(MOC), 32'd1);
                check({name, "_hold_data"}, DataOut, e.data);
            end
        end
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk);
        #1;
        check({name, "_moc_fall"}, 32'(MOC), 32'd0);
    endtask

    initial begin
        int moc_seen;
        Clr = 1'b1; MOV = 1'b0; RW = 1'b0; Addr = '0; DataIn = '0; Type = 2'b00;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_moc", 32'(MOC), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_dout", DataOut, 32'h0);
        Clr = 1'b0;

        do_req("wr_word_010", 1'b0, 9'h010, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req("rd_byte_010", 1'b1, 9'h010, 2'b00, 32'h0, 32'h000000DE, 1'b0, 0);
        do_req("rd_half_012", 1'b1, 9'h012, 2'b01, 32'h0, 32'h0000BEEF, 1'b0, 4);
        do_req("rd_word_010", 1'b1, 9'h010, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        do_req("wr_byte_011", 1'b0, 9'h011, 2'b00, 32'h123456A5, 32'h0, 1'b0, 0);
        do_req("rd_word_010b", 1'b1, 9'h010, 2'b10, 32'h0, 32'hDEA5BEEF, 1'b0, 0);
        do_req("wr_half_014", 1'b0, 9'h014, 2'b01, 32'hFFFF1234, 32'h0, 1'b0, 0);
        do_req("rd_half_014", 1'b1, 9'h014, 2'b01, 32'h0, 32'h00001234, 1'b0, 0);
        do_req("rd_byte_013", 1'b1, 9'h013, 2'b00, 32'h0, 32'h000000EF, 1'b0, 0);
        do_req("wr_illegal", 1'b0, 9'h010, 2'b11, 32'h00000000, 32'h0, 1'b1, 0);
        do_req("rd_word_010c", 1'b1, 9'h010, 2'b10, 32'h0, 32'hDEA5BEEF, 1'b0, 0);

        // Aborted write: MOV dropped during the second BUSY cycle.
        do_req("wr_byte_020", 1'b0, 9'h020, 2'b00, 32'h00000077, 32'h0, 1'b0, 0);
        @(negedge Clk);
        MOV = 1'b1; RW = 1'b0; Addr = 9'h020; Type = 2'b00; DataIn = 32'h55;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        MOV = 1'b0;
        moc_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk);
            #1;
            if (MOC !== 1'b0) moc_seen++;
        end
        check("abort_no_moc", 32'(moc_seen), 32'd0);
        do_req("rd_byte_020", 1'b1, 9'h020, 2'b00, 32'h0, 32'h00000077, 1'b0, 0);
        do_req("rd_illegal", 1'b1, 9'h000, 2'b11, 32'h0, 32'h0, 1'b1, 0);

        // Misaligned word writes and modulo-512 wrap.
        do_req("wr_word_000", 1'b0, 9'h000, 2'b10, 32'hA0A1A2A3, 32'h0, 1'b0, 0);
        do_req("wr_word_003", 1'b0, 9'h003, 2'b10, 32'h01020304, 32'h0, ALIGN, 0);
        do_req("wr_word_1fe", 1'b0, 9'h1FE, 2'b10, 32'hCAFEF00D, 32'h0, ALIGN, 0);
`ifdef MEM_ALIGN_CHECK_EN
        do_req("rd_word_000", 1'b1, 9'h000, 2'b10, 32'h0, 32'hA0A1A2A3, 1'b0, 0);
        do_req("rd_half_odd", 1'b1, 9'h001, 2'b01, 32'h0, 32'h0, 1'b1, 0);
`else
        do_req("rd_word_000", 1'b1, 9'h000, 2'b10, 32'h0, 32'hF00DA201, 1'b0, 0);
        do_req("rd_half_004", 1'b1, 9'h004, 2'b01, 32'h0, 32'h00000203, 1'b0, 0);
        do_req("rd_half_1fe", 1'b1, 9'h1FE, 2'b01, 32'h0, 32'h0000CAFE, 1'b0, 0);
`endif

        // Clr during BUSY of a word write must not commit it.
        do_req("wr_word_040", 1'b0, 9'h040, 2'b10, 32'h11223344, 32'h0, 1'b0, 0);
        @(negedge Clk);
        MOV = 1'b1; RW = 1'b0; Addr = 9'h040; Type = 2'b10; DataIn = 32'hAABBCCDD;
        @(posedge Clk);
        @(negedge Clk);
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        check("clr_moc", 32'(MOC), 32'd0);
        check("clr_dout", DataOut, 32'h0);
        check("clr_err", 32'(Err), 32'd0);
        @(negedge Clk);
        Clr = 1'b0;
        MOV = 1'b0;
        model_dout = 32'h0;
        do_req("rd_word_040", 1'b1, 9'h040, 2'b10, 32'h0, 32'h11223344, 1'b0, 0);

        repeat (3) @(posedge Clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_mem_responder.md
SYNC_MEM_RESPONDER -- requirements
Module: sync_mem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is Clk and the reset port is Clr.
REQ-002 Parameter WAIT_CYCLES, default 2: number of BUSY cycles inserted before an access completes; legal range 0-15.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Clr  input  1  synchronous active-high reset.
REQ-005 MOV  input  1  memory operation valid; held high by the initiator until MOC is seen.
REQ-006 RW  input  1  1 = read, 0 = write.
REQ-007 Addr  input  9  byte address into the 512-byte array.
REQ-008 DataIn  input  32  write data, right-justified.
REQ-009 Type  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-010 DataOut  output  32  read data, right-justified and zero-extended.
REQ-011 MOC  output  1  memory operation complete.
REQ-012 Err  output  1  access rejected; valid while MOC = 1.

Function
REQ-013 Storage SHALL be a 512 x 8 array with big-endian byte order: the lowest address holds the most-significant byte.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 IDLE with MOV = 1 SHALL latch Addr, RW, Type and DataIn, load the wait counter with WAIT_CYCLES, and enter BUSY.
REQ-016 Inputs SHALL be ignored after latching until the block returns to IDLE.
REQ-017 BUSY SHALL decrement the counter each cycle.
REQ-018 When the counter is 0 in BUSY, the block SHALL perform the access on that edge and enter DONE.
REQ-019 With WAIT_CYCLES = 0, BUSY SHALL last exactly 1 cycle.
REQ-020 Latency from the edge that samples MOV = 1 to MOC = 1 SHALL be WAIT_CYCLES + 2 clock edges.
REQ-021 DONE SHALL drive MOC = 1 and hold DataOut and Err stable until MOV = 0 is sampled, then return to IDLE with MOC = 0 on the same edge.
REQ-022 A new request SHALL NOT be accepted in the cycle MOC falls.
REQ-023 MOV = 0 sampled in BUSY SHALL abort the operation: no write, no MOC pulse, return to IDLE.
REQ-024 A write SHALL update only the 1, 2 or 4 bytes selected by Type, using the low bits of DataIn.
REQ-025 A write SHALL leave DataOut unchanged.
REQ-026 A read SHALL load DataOut: byte into [7:0], halfword into [15:0], word into [31:0], with all upper bits zero.
REQ-027 Type = 11 SHALL complete with Err = 1, no write, and DataOut unchanged.
REQ-028 Address arithmetic SHALL wrap modulo 512 for multi-byte accesses.
REQ-029 Multi-byte wrap SHALL only arise when alignment checking is disabled (see REQ-035).
REQ-030 MOC and Err SHALL change only on rising edges of Clk.

Reset
REQ-031 Clr = 1 at a rising edge SHALL force IDLE, MOC = 0, Err = 0, DataOut = 32'h00000000 and counter = 0.
REQ-032 Clr SHALL take priority over every other input.
REQ-033 Clr asserted in BUSY or DONE SHALL abort the operation and SHALL NOT commit any pending write.
REQ-034 Clr SHALL NOT clear array contents.

Configuration
REQ-035 Macro MEM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-036 With MEM_ALIGN_CHECK_EN defined, a halfword at odd Addr, or a word with Addr[1:0] != 00, SHALL complete with Err = 1, no write, and DataOut unchanged.
REQ-037 Without MEM_ALIGN_CHECK_EN, misaligned accesses SHALL proceed at the given address with modulo-512 wrap, and Err SHALL be set only for Type = 11.

Verification
REQ-038 Write word 32'hDEADBEEF to Addr 0x010, then byte read at 0x010 -> DataOut = 32'h000000DE; halfword read at 0x012 -> 32'h0000BEEF.
REQ-039 WAIT_CYCLES = 3, read request -> MOC rises on the 5th edge after MOV is sampled; MOV held 4 further cycles -> MOC stays 1 with DataOut stable, and falls on the first edge after MOV = 0.
REQ-040 Write byte 8'h55 to 0x020 with MOV dropped in the 2nd BUSY cycle -> no MOC; a subsequent read of 0x020 returns the prior contents.
REQ-041 Word write with Addr = 0x003 -> with MEM_ALIGN_CHECK_EN: Err = 1, MOC = 1, array unchanged; without it: bytes 0x003-0x006 are written and Err = 0.
REQ-042 Clr pulsed in BUSY of a word write to 0x040 -> next cycle MOC = 0, DataOut = 0, state IDLE; a read of 0x040 returns the old value.
REQ-043 Type = 11 read -> MOC = 1, Err = 1, DataOut keeps its previous value.
